ps2_mouse_tracker: RTL and testbench

PS2_MOUSE_TRACKER -- requirements
Module: ps2_mouse_tracker

---
 rtl/ps2_mouse_tracker.sv | 144 ++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet tracker: assembles 3-byte movement packets into a clamped
// screen position and button state, flagging sync, line and timeout errors.
//
// state | meaning
// B0    | waiting for a header byte (bit 3 set)
// B1    | header latched, waiting for the X magnitude byte
// B2    | X latched, waiting for the Y magnitude byte; packet applied on arrival
module ps2_mouse_tracker #(
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        pxl_clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [11:0] mouse_x_pos,
    output logic [11:0] mouse_y_pos,
    output logic [2:0]  buttons,
    output logic        mouse_err,
    output logic        new_event
);
    localparam int                CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]     TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [13:0] X_MAX_S = 14'(X_MAX);
    localparam logic signed [13:0] Y_MAX_S = 14'(Y_MAX);
    localparam logic [11:0]       X_RST    = 12'(X_MAX / 2);
    localparam logic [11:0]       Y_RST    = 12'(Y_MAX / 2);

    typedef enum logic [1:0] {B0, B1, B2} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  tmo_cnt, tmo_cnt_nxt;
    // header without the always-one sync bit: {y_ovf, x_ovf, y_sign, x_sign, btn[2:0]}
    logic [6:0]     hdr, hdr_nxt;
    logic [7:0]     byte1, byte1_nxt;
    logic [11:0]    x_nxt, y_nxt;
    logic [2:0]     buttons_nxt;
    logic           err_nxt, event_nxt, fault;

    logic signed [13:0] dx, dy, x_sum, y_sum;
    logic [11:0]        x_clamp, y_clamp;

    always_comb begin
        dx    = hdr[5] ? 14'sd0 : {{6{hdr[3]}}, byte1};
        dy    = hdr[6] ? 14'sd0 : {{6{hdr[4]}}, rx_data};
        x_sum = $signed({2'b00, mouse_x_pos}) + dx;
        y_sum = $signed({2'b00, mouse_y_pos}) - dy;
        if (x_sum < 14'sd0)
            x_clamp = '0;
        else if (x_sum > X_MAX_S)
            x_clamp = X_MAX_S[11:0];
        else
            x_clamp = x_sum[11:0];
        if (y_sum < 14'sd0)
            y_clamp = '0;
        else if (y_sum > Y_MAX_S)
            y_clamp = Y_MAX_S[11:0];
        else
            y_clamp = y_sum[11:0];
    end

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        hdr_nxt     = hdr;
        byte1_nxt   = byte1;
        x_nxt       = mouse_x_pos;
        y_nxt       = mouse_y_pos;
        buttons_nxt = buttons;
        err_nxt     = mouse_err;
        event_nxt   = 1'b0;
        fault       = 1'b0;

        if (rx_valid) begin
            // a byte always beats a coincident timeout
            tmo_cnt_nxt = '0;
            if (rx_err) begin
                fault = 1'b1;
            end else begin
                case (state)
                    B0: begin
                        if (rx_data[3]) begin
                            hdr_nxt   = {rx_data[7:4], rx_data[2:0]};
                            state_nxt = B1;
                        end else begin
                            fault = 1'b1;
                        end
                    end
                    B1: begin
                        byte1_nxt = rx_data;
                        state_nxt = B2;
                    end
                    B2: begin
                        x_nxt       = x_clamp;
                        y_nxt       = y_clamp;
                        buttons_nxt = hdr[2:0];
                        err_nxt     = 1'b0;
                        event_nxt   = 1'b1;
                        state_nxt   = B0;
                    end
                    default: fault = 1'b1;
                endcase
            end
        end else if (state != B0) begin
            if (tmo_cnt == TMO_LAST)
                fault = 1'b1;
            else
                tmo_cnt_nxt = tmo_cnt + CW'(1);
        end

        if (fault) begin
            state_nxt   = B0;
            tmo_cnt_nxt = '0;
            err_nxt     = 1'b1;
            event_nxt   = 1'b1;
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            state       <= B0;
            tmo_cnt     <= '0;
            hdr         <= '0;
            byte1       <= '0;
            mouse_x_pos <= X_RST;
            mouse_y_pos <= Y_RST;
            buttons     <= '0;
            mouse_err   <= 1'b0;
            new_event   <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            hdr         <= hdr_nxt;
            byte1       <= byte1_nxt;
            mouse_x_pos <= x_nxt;
            mouse_y_pos <= y_nxt;
            buttons     <= buttons_nxt;
            mouse_err   <= err_nxt;
            new_event   <= event_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: directed packets plus random byte streams,
// checked every cycle against a packet-level reference model.
module tb_ps2_mouse_tracker;
    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;
    localparam int TMO   = 64;

    logic        pxl_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_err  = 1'b0;
    logic [11:0] mouse_x_pos, mouse_y_pos;
    logic [2:0]  buttons;
    logic        mouse_err, new_event;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         mx, my, mbtn, merr;
    logic [7:0] pkt[$];
    int         idle_cnt;

    ps2_mouse_tracker #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYCLES(TMO)) dut (
        .pxl_clk(pxl_clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_err(rx_err), .mouse_x_pos(mouse_x_pos), .mouse_y_pos(mouse_y_pos),
        .buttons(buttons), .mouse_err(mouse_err), .new_event(new_event)
    );

    always #20 pxl_clk = ~pxl_clk;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic cmp(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int ev);
        cmp({tag, ".new_event"}, int'(new_event), ev);
        cmp({tag, ".x"}, int'(mouse_x_pos), mx);
        cmp({tag, ".y"}, int'(mouse_y_pos), my);
        cmp({tag, ".buttons"}, int'(buttons), mbtn);
        cmp({tag, ".mouse_err"}, int'(mouse_err), merr);
    endtask

    task automatic model_reset();
        mx = X_MAX / 2; my = Y_MAX / 2; mbtn = 0; merr = 0;
        pkt.delete();
        idle_cnt = 0;
    endtask

    // returns 1 when the byte completes an event
    function automatic int model_byte(input logic [7:0] d, input logic e);
        logic [7:0] h, b1;
        int dxv, dyv;
        if (e) begin
            pkt.delete(); merr = 1; return 1;
        end
        if (pkt.size() == 0) begin
            if (d[3]) begin pkt.push_back(d); return 0; end
            merr = 1; return 1;
        end
        if (pkt.size() == 1) begin pkt.push_back(d); return 0; end
        h = pkt[0]; b1 = pkt[1];
        dxv = h[6] ? 0 : (h[4] ? int'(b1) - 256 : int'(b1));
        dyv = h[7] ? 0 : (h[5] ? int'(d) - 256 : int'(d));
        mx = clampi(mx + dxv, X_MAX);
        my = clampi(my - dyv, Y_MAX);
        mbtn = int'(h[2:0]);
        merr = 0;
        pkt.delete();
        return 1;
    endfunction

    task automatic idle(input int n);
        int ev;
        for (int i = 0; i < n; i++) begin
            @(posedge pxl_clk); #1;
            idle_cnt++;
            ev = 0;
            if (pkt.size() > 0 && idle_cnt == TMO) begin
                pkt.delete(); merr = 1; ev = 1;
            end
            check_all("idle", ev);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e, input int gap);
        int ev;
        @(negedge pxl_clk);
        rx_data = d; rx_valid = 1'b1; rx_err = e;
        @(posedge pxl_clk); #1;
        rx_valid = 1'b0; rx_err = 1'b0;
        ev = model_byte(d, e);
        idle_cnt = 0;
        check_all("byte", ev);
        idle(gap);
    endtask

    task automatic do_reset(input int n);
        @(negedge pxl_clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            rx_data = 8'h08; rx_valid = 1'b1; rx_err = 1'($urandom_range(0, 1));
            @(posedge pxl_clk); #1;
            check_all("in_reset", 0);
            @(negedge pxl_clk);
        end
        rx_valid = 1'b0; rx_err = 1'b0;
        reset = 1'b0;
        idle(3);
    endtask

    initial begin
        logic [7:0] d;
        model_reset();
        do_reset(4);
        cmp("rst.x", int'(mouse_x_pos), 319);
        cmp("rst.y", int'(mouse_y_pos), 239);

        send(8'h09, 1'b0, 2); send(8'h10, 1'b0, 2); send(8'h05, 1'b0, 0);
        cmp("pkt1.x", int'(mouse_x_pos), 335);
        cmp("pkt1.y", int'(mouse_y_pos), 234);
        cmp("pkt1.btn", int'(buttons), 1);
        idle(3);

        do_reset(2);
        send(8'h38, 1'b0, 2); send(8'h00, 1'b0, 2); send(8'h00, 1'b0, 0);
        cmp("clamp.x", int'(mouse_x_pos), 63);
        cmp("clamp.y", int'(mouse_y_pos), 479);
        idle(3);

        send(8'h00, 1'b0, 0);
        cmp("sync.err", int'(mouse_err), 1);
        idle(3);
        send(8'h08, 1'b0, 2); send(8'h01, 1'b0, 2); send(8'h00, 1'b0, 0);
        cmp("after_sync.x", int'(mouse_x_pos), 64);
        idle(3);

        // timeout after a lone header, then a fresh header is accepted
        send(8'h08, 1'b0, TMO + 4);
        cmp("tmo.err", int'(mouse_err), 1);
        send(8'h08, 1'b0, 2); send(8'h02, 1'b0, 2); send(8'h00, 1'b0, 3);
        cmp("after_tmo.x", int'(mouse_x_pos), 66);

        send(8'h48, 1'b0, 2); send(8'h7F, 1'b0, 2); send(8'h01, 1'b0, 3);
        cmp("xovf.x", int'(mouse_x_pos), 66);
        cmp("xovf.y", int'(mouse_y_pos), 478);

        send(8'h48, 1'b0, 2);
        do_reset(3);
        send(8'h09, 1'b0, 2); send(8'h01, 1'b0, 2); send(8'h01, 1'b0, 3);

        // line error mid-packet, then a byte landing exactly on the timeout cycle
        send(8'h0A, 1'b0, 2); send(8'h05, 1'b1, 3);
        send(8'h0A, 1'b0, TMO - 1); send(8'h05, 1'b0, TMO - 1); send(8'hFB, 1'b0, 3);

        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) != 0 && pkt.size() == 0) d[3] = 1'b1;
            send(d, 1'($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 19) == 0) ? TMO + 2 : int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
